// File: rtl/image_loader.sv
// Loads a WIDTH x HEIGHT pixel stream row-major into an internal buffer and
// exposes a one-cycle-latency read port for the downstream pipeline.
module image_loader #(
  parameter int WIDTH  = 50,
  parameter int HEIGHT = 50,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [5:0]        row,
  output logic [5:0]        col,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int TOTAL = WIDTH * HEIGHT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [5:0]          row_q, row_d;
  logic [5:0]          col_q, col_d;
  logic                err_q, err_d;
  logic                in_ready_q;
  logic [PIX_W-1:0]    rd_data_q;
  logic                xfer;

  logic [PIX_W-1:0]    mem [TOTAL];

  // Handshake: a pixel moves on any cycle with in_valid && in_ready; in_ready
  // is a register that depends only on the FSM, never on in_valid.
  assign xfer = in_valid && in_ready_q && !rst;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (start) err_d = 1'b1;
        if (xfer) begin
          if (addr_q == ADDR_W'(TOTAL - 1)) begin
            // Last pixel: counters park at the origin rather than row HEIGHT.
            state_d = DONE;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == 6'(WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + 6'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == LOAD);
      rd_data_q  <= (int'(rd_addr) < TOTAL) ? mem[rd_addr] : '0;
    end
  end

  // Buffer is not reset; reads above see the pre-write value (read-first).
  always_ff @(posedge clk) begin
    if (xfer) mem[addr_q] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign row       = row_q;
  assign col       = col_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed testbench for image_loader: full load, row/col tracking, stalls,
// illegal restart, reset mid-load and read-port edge cases.
module tb_image_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int xfers;
  int busy_cycles;
  int stall_bad;
  logic [7:0] model_mem [2500];
  logic [7:0] exp_q [$];

  image_loader #(.WIDTH(50), .HEIGHT(50), .PIX_W(8), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .row(row), .col(col),
    .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Driver: pushes n pixels starting at index first; optional idle cycle
  // between pixels, optional 0xFF data, optional start pulse at one index.
  task automatic stream(input int first, input int n, input bit stall,
                        input bit ff, input int start_at);
    for (int k = 0; k < n; k++) begin
      int idx;
      int guard;
      logic [5:0] r0, c0;
      idx = first + k;
      guard = 0;
      if (stall && k > 0) begin
        in_valid = 1'b0;
        r0 = row;
        c0 = col;
        if (busy === 1'b1) busy_cycles++;
        @(negedge clk);
        if (row !== r0 || col !== c0) stall_bad++;
      end
      in_valid = 1'b1;
      in_data  = ff ? 8'hFF : 8'(idx);
      start    = (idx == start_at);
      while (in_ready !== 1'b1 && guard < 8) begin
        @(negedge clk);
        guard++;
      end
      if (guard == 8) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: in_ready=%b at pixel %0d, required 1", in_ready, idx);
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      start = 1'b0;
      model_mem[idx] = in_data;
      xfers++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done/err=%b%b%b%b, required 0000", in_ready, busy, done, err);
    end
    checks++;
    if (row !== 6'd0 || col !== 6'd0 || rd_data !== 8'h00 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: row=%0d col=%0d rd_data=%h state=%0d, required 0 0 00 0", row, col, rd_data, dbg_state);
    end
  endtask

  task automatic test_full_load();
    logic [11:0] addrs [4] = '{12'd0, 12'd49, 12'd50, 12'd2499};
    logic [7:0]  exps  [4] = '{8'h00, 8'h31, 8'h32, 8'hC3};
    xfers = 0; busy_cycles = 0;
    pulse_start();
    stream(0, 49, 1'b0, 1'b0, -1);
    checks++;
    if (row !== 6'd0 || col !== 6'd49) begin
      errors++;
      $display("FAIL rowcol_49: row=%0d col=%0d, required 0 49", row, col);
    end
    stream(49, 1, 1'b0, 1'b0, -1);
    checks++;
    if (row !== 6'd1 || col !== 6'd0) begin
      errors++;
      $display("FAIL rowcol_50: row=%0d col=%0d, required 1 0", row, col);
    end
    stream(50, 2450, 1'b0, 1'b0, -1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || row !== 6'd0 || col !== 6'd0) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b ready=%b row=%0d col=%0d, required 1 0 0 0 0", done, busy, in_ready, row, col);
    end
    checks++;
    if (busy_cycles !== 2500 || xfers !== 2500) begin
      errors++;
      $display("FAIL full_busy_count: busy_cycles=%0d xfers=%0d, required 2500 2500", busy_cycles, xfers);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_after: ready=%b done=%b, required 0 1", in_ready, done);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (rd_data !== exps[i]) begin
        errors++;
        $display("FAIL full_read: addr=%0d rd_data=%h, required %h", addrs[i], rd_data, exps[i]);
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    xfers = 0; stall_bad = 0; bad = 0;
    for (int i = 0; i < 2500; i++) model_mem[i] = 8'h5A;
    pulse_start();
    stream(0, 2500, 1'b1, 1'b0, -1);
    checks++;
    if (stall_bad !== 0 || xfers !== 2500 || done !== 1'b1) begin
      errors++;
      $display("FAIL stall_counters: stall_moves=%0d xfers=%0d done=%b, required 0 2500 1", stall_bad, xfers, done);
    end
    // Scoreboard: expected bytes queued in address order, one-cycle read latency.
    for (int a = 0; a < 2500; a++) begin
      exp_q.push_back(8'(a));
      rd_addr = 12'(a);
      @(negedge clk);
      if (rd_data !== exp_q.pop_front()) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_image: %0d bytes differ, required 0", bad);
    end
  endtask

  task automatic test_illegal_restart();
    do_reset();
    pulse_start();
    stream(0, 100, 1'b0, 1'b0, -1);
    stream(100, 1, 1'b0, 1'b0, 100);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || row !== 6'd2 || col !== 6'd1) begin
      errors++;
      $display("FAIL restart_err: err=%b busy=%b row=%0d col=%0d, required 1 1 2 1", err, busy, row, col);
    end
    stream(101, 2399, 1'b0, 1'b0, -1);
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || row !== 6'd0 || col !== 6'd0) begin
      errors++;
      $display("FAIL restart_complete: err=%b done=%b row=%0d col=%0d, required 1 1 0 0", err, done, row, col);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1 || row !== 6'd0 || col !== 6'd0) begin
      errors++;
      $display("FAIL restart_from_done: err=%b done=%b busy=%b ready=%b row=%0d col=%0d, required 0 0 1 1 0 0",
               err, done, busy, in_ready, row, col);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    stream(0, 1000, 1'b0, 1'b0, -1);
    in_valid = 1'b1; in_data = 8'hAB; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || row !== 6'd0 || col !== 6'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state: ready=%b busy=%b done=%b row=%0d col=%0d state=%0d, required 0 0 0 0 0 0",
               in_ready, busy, done, row, col, dbg_state);
    end
    rd_addr = 12'd999;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'hE7) begin
      errors++;
      $display("FAIL midreset_keep999: rd_data=%h, required e7", rd_data);
    end
    rd_addr = 12'd1000;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'hE8) begin
      errors++;
      $display("FAIL midreset_nowrite1000: rd_data=%h, required e8", rd_data);
    end
    pulse_start();
    stream(0, 2500, 1'b0, 1'b1, -1);
    rd_addr = 12'd999;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'hFF || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reload: rd_data=%h done=%b, required ff 1", rd_data, done);
    end
  endtask

  task automatic test_read_edges();
    rd_addr = 12'd2500;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL read_2500: rd_data=%h, required 00", rd_data);
    end
    rd_addr = 12'd4095;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL read_4095: rd_data=%h, required 00", rd_data);
    end
    pulse_start();
    stream(0, 10, 1'b0, 1'b0, -1);
    in_valid = 1'b1; in_data = 8'h0A; rd_addr = 12'd10;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL read_first_old: rd_data=%h, required ff", rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h0A) begin
      errors++;
      $display("FAIL read_first_new: rd_data=%h, required 0a", rd_data);
    end
    checks++;
    if (row !== 6'd0 || col !== 6'd11) begin
      errors++;
      $display("FAIL read_edges_pos: row=%0d col=%0d, required 0 11", row, col);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_illegal_restart();
    test_reset_mid_load();
    test_read_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream feeder for the pipeline's 50x50, 8-bit image memory (2500 bytes).
- Accepts a pixel byte stream over a valid/ready handshake and writes it row-major into an internal image buffer.
- Reports load progress and completion.
- Exposes a registered read port through which the pipeline fetches pixels.

Parameters:
WIDTH, 50, pixels per row
HEIGHT, 50, rows per image
PIX_W, 8, bits per pixel
ADDR_W, 12, address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin loading a new image (sampled per cycle)
in_data  in  PIX_W  incoming pixel byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a pixel this cycle
rd_addr  in  ADDR_W  pipeline read address
rd_data  out  PIX_W  pixel at rd_addr, one cycle later
busy  out  1  high while in LOAD
done  out  1  high while in DONE (image complete)
row  out  6  row of next pixel to be written
col  out  6  column of next pixel to be written
err  out  1  sticky: start asserted while busy

Behaviour:
- Clock and reset:
  - One clock domain (clk). rst is synchronous, active-high and overrides all other inputs in that cycle.
  - Reset values: in_ready=0, busy=0, done=0, row=0, col=0, err=0, rd_data=0, state=IDLE, write address=0.
  - Buffer contents are NOT cleared by reset.
- Constants: TOTAL = WIDTH*HEIGHT.
- Transfer rule: a pixel transfers on a cycle where in_valid && in_ready; nothing else writes the buffer.
- in_ready: registered; equals (state==LOAD). Independent of in_valid within the cycle.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD; addr, row and col cleared to 0; err cleared.
  - LOAD: each transfer writes mem[addr]=in_data, then addr+1 and col+1.
    - When col==WIDTH-1: col wraps to 0 and row increments.
    - A transfer at addr==TOTAL-1 -> DONE. In that case row/col go to 0/0 (not HEIGHT/0), and in_ready is 0 from the next cycle.
  - LOAD with start=1: start is ignored, err set to 1 (sticky). A transfer in the same cycle still completes normally.
  - DONE: done=1. start=1 -> LOAD with addr, row and col cleared, done=0 and err cleared.
- Stalls: in_valid=0 during LOAD holds all counters. No timeout.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, regardless of state (1-cycle latency).
  - rd_addr >= TOTAL gives rd_data=0.
  - Same-cycle write and read to the same address is read-first: rd_data returns the old value.
- Reset mid-load: rst during LOAD -> IDLE with all outputs at reset values. Pixels already written stay in the buffer. A following start reloads from address 0.
- Arithmetic: addr, row and col are unsigned counters. No wrap past TOTAL-1, because the FSM leaves LOAD first.

Test Plan:
- Full load: rst 1 cycle; start; stream bytes (i mod 256) for i=0..2499 with continuous in_valid. Required: busy=1 for exactly 2500 transfer cycles; done=1 after the last one; in_ready=0 afterwards; then rd_addr=0, 49, 50, 2499 returns 0x00, 0x31, 0x32, 0xC3 one cycle later.
- Row/col tracking: after 49 transfers, row=0 and col=49. After the 50th, row=1 and col=0. After 2500 transfers, row=0 and col=0 with done=1.
- Back-pressure/stall: in_valid toggles every other cycle during the load. Required: counters advance only on valid cycles; the final image is identical to the full-load case; total transfers = 2500.
- Illegal restart: start pulsed at transfer 100 of a load. Required: err=1 and stays 1; the load continues to 2500 unaffected. A new start in DONE clears err and done and restarts at row 0 / col 0.
- Reset mid-load: rst at transfer 1000. Required: next cycle in_ready=0, busy=0, row=0, col=0, done=0; rd_addr=999 still returns the byte previously written. Restart and a reload of 0xFF bytes gives rd_addr=999 -> 0xFF.
- Read edge cases: rd_addr=2500 or 4095 -> rd_data=0. A read of address 10 in the same cycle as the write of address 10 returns the old value; the next read returns the new value.
